hm10_tx_arbiter: RTL and testbench
==================================

// Module: hm10_tx_arbiter
// PURPOSE
//  Shares the single HM-10 UART transmitter (drives bt_rxd via uart_tx) between two byte requesters:
//  ch0 = Opal Kelly host command/data path, ch1 = FPGA data stream. Arbitrates per MESSAGE, not per byte:
//  no interleaving, round-robin between messages, programmable inter-byte gap, ch1 gated on BT connection.
//  Sits inside FBC_w_OK between requester FIFOs and uart_tx.
// PARAMETERS
//  SPACE_W      10   width of uart_spacing_limit / gap counter
//  STALL_LIMIT  255  cycles owner may hold req low mid-message before forced release (>=1)
// PORTS
//  clock               in   1   system clock (1 MHz on board)
//  resetn              in   1   asynchronous active-low reset
//  bt_state            in   1   HM-10 STATE pin, 1 = connected
//  uart_spacing_limit  in   10  idle cycles inserted after each byte (0 = none)
//  req                 in   2   req[i]: channel i has a byte on data_i
//  last                in   2   last[i]: byte on data_i ends the message (sampled with ack)
//  data_0, data_1      in   8   byte offered by ch0 / ch1
//  ack                 out  2   1-cycle pulse: byte of channel i consumed
//  abort               out  2   1-cycle pulse: channel i message terminated early
//  grant               out  2   one-hot current message owner, 0 when idle
//  tx_data             out  8   byte to uart_tx, valid with tx_start
//  tx_start            out  1   1-cycle start pulse to uart_tx
//  tx_busy             in   1   uart_tx busy
// BEHAVIOUR
//  Reset (async, resetn=0): state IDLE; ack, abort, grant, tx_start = 0; tx_data = 8'h00; rr pointer = ch1
//   (so ch0 wins first contention); gap and stall counters = 0. Reset mid-byte abandons message silently.
//  Eligibility: ch0 = req[0]; ch1 = req[1] & bt_state.
//  IDLE: no eligible -> stay. One eligible -> owner. Both -> channel != rr pointer. Next cycle LOAD;
//   grant asserted from LOAD through end of message; rr pointer <= owner on grant.
//  LOAD: if req[owner] (and bt_state for ch1) and tx_busy=0: tx_data<=data_owner, tx_start=1, ack[owner]=1
//   same cycle, capture last[owner] -> SEND. If req low: stall counter++; at STALL_LIMIT -> abort[owner]
//   pulse, release -> IDLE. Stall counter clears on every accepted byte.
//  SEND: wait for tx_busy rising then falling; if tx_busy not seen high within 2 cycles of tx_start, byte
//   counts as sent. -> GAP.
//  GAP: count uart_spacing_limit cycles (0 -> one-cycle pass-through); limit sampled on entry. Then:
//   captured last=1 -> release, grant=0, IDLE; else -> LOAD same owner.
//  bt_state falls while ch1 owns: current byte completes (SEND/GAP run out), then abort[1] pulse and
//   release instead of LOAD. ch0 ownership ignores bt_state.
//  Minimum byte-to-byte period = 1 (LOAD) + byte time + gap + 1. ack never pulses to a non-owner.
//  Single-byte message = req with last=1 on first byte. Both ack bits never high together.
// TESTING
//  1 ch0 sends 3-byte msg A1,A2,A3(last), spacing=0, uart_tx model busy 10 cyc -> 3 tx_start, 3 ack[0], grant 01 throughout, then 00.
//  2 req=11 from reset, bt_state=1, 2-byte msgs each -> order ch0,ch0,ch1,ch1 on tx_data; repeat -> ch0 again (round robin), no interleave.
//  3 spacing=5 -> exactly 5 idle cycles between tx_busy fall and next tx_start (+LOAD cycle); spacing=0 -> back-to-back.
//  4 ch1 mid-message (byte 2 of 4), bt_state->0 -> byte 2 completes, abort[1]=1 one cycle, grant 00; ch0 pending then served.
//  5 ch0 drops req after byte 1 of 3 for STALL_LIMIT cycles -> abort[0] pulse, release; ch1 req=1,bt_state=0 -> no grant.
//  6 resetn low during SEND -> all outputs 0 immediately; after release, rr pointer = ch1 (ch0 wins contention).

Source files
------------

// File: rtl/hm10_tx_arbiter.sv
// hm10_tx_arbiter: shares one HM-10 UART transmitter between the host command
// path (ch0) and the FPGA data stream (ch1). Ownership is held for a whole
// message, alternates round-robin under contention, inserts a programmable
// idle gap after every byte, and gates ch1 on the Bluetooth link being up.
module hm10_tx_arbiter #(
    parameter int unsigned SPACE_W     = 10,
    parameter int unsigned STALL_LIMIT = 255
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               bt_state,
    input  logic [SPACE_W-1:0] uart_spacing_limit,
    input  logic [1:0]         req,
    input  logic [1:0]         last,
    input  logic [7:0]         data_0,
    input  logic [7:0]         data_1,
    output logic [1:0]         ack,
    output logic [1:0]         abort,
    output logic [1:0]         grant,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy
);

    localparam int unsigned STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSend,
        StGap
    } state_e;

    state_e              r_state;
    logic                r_owner;    // 0 = ch0, 1 = ch1
    logic                r_rr;       // last channel granted; the other wins a tie
    logic                r_last;     // captured last flag of the byte in flight
    logic                r_seen;     // tx_busy observed high for the byte in flight
    logic [1:0]          r_wait;     // cycles since tx_start without tx_busy
    logic [SPACE_W-1:0]  r_gap;
    logic [STALL_W-1:0]  r_stall;
    logic [1:0]          r_ack;
    logic [1:0]          r_abort;
    logic [1:0]          r_grant;
    logic [7:0]          r_tx_data;
    logic                r_tx_start;

    logic                w_elig0;
    logic                w_elig1;
    logic                w_any;
    logic                w_pick;
    logic [1:0]          w_pick_oh;
    logic                w_own_ok;
    logic [7:0]          w_own_data;
    logic                w_own_last;
    logic                w_bt_lost;
    logic                w_stall_done;
    logic                w_gap_done;

    // Eligibility and tie-break: ch1 only counts while the link is up.
    assign w_elig0   = req[0];
    assign w_elig1   = req[1] & bt_state;
    assign w_any     = w_elig0 | w_elig1;
    assign w_pick    = (w_elig0 & w_elig1) ? ~r_rr : w_elig1;
    assign w_pick_oh = w_pick ? 2'b10 : 2'b01;

    // Owner-side views of the requester interface.
    assign w_own_ok     = r_owner ? w_elig1 : w_elig0;
    assign w_own_data   = r_owner ? data_1 : data_0;
    assign w_own_last   = r_owner ? last[1] : last[0];
    assign w_bt_lost    = r_owner & ~bt_state;
    assign w_stall_done = (r_stall == STALL_W'(STALL_LIMIT - 1));
    // A limit of 0 or 1 both give a single gap cycle.
    assign w_gap_done   = (r_gap <= SPACE_W'(1));

    assign ack      = r_ack;
    assign abort    = r_abort;
    assign grant    = r_grant;
    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;

    // Message-level arbitration FSM; all outputs are registered here.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= StIdle;
            r_owner    <= 1'b0;
            r_rr       <= 1'b1;
            r_last     <= 1'b0;
            r_seen     <= 1'b0;
            r_wait     <= 2'd0;
            r_gap      <= '0;
            r_stall    <= '0;
            r_ack      <= 2'b00;
            r_abort    <= 2'b00;
            r_grant    <= 2'b00;
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
        end else begin
            // Pulse outputs last exactly one cycle.
            r_ack      <= 2'b00;
            r_abort    <= 2'b00;
            r_tx_start <= 1'b0;

            case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_owner <= w_pick;
                        r_rr    <= w_pick;
                        r_grant <= w_pick_oh;
                        r_stall <= '0;
                        r_state <= StLoad;
                    end
                end

                StLoad: begin
                    if (w_bt_lost) begin
                        // Link dropped between bytes of a ch1 message.
                        r_abort <= 2'b10;
                        r_grant <= 2'b00;
                        r_state <= StIdle;
                    end else if (w_own_ok) begin
                        if (!tx_busy) begin
                            r_tx_data  <= w_own_data;
                            r_tx_start <= 1'b1;
                            r_ack      <= r_grant;
                            r_last     <= w_own_last;
                            r_stall    <= '0;
                            r_seen     <= 1'b0;
                            r_wait     <= 2'd0;
                            r_state    <= StSend;
                        end
                    end else if (w_stall_done) begin
                        // Owner went quiet mid-message for too long.
                        r_abort <= r_grant;
                        r_grant <= 2'b00;
                        r_stall <= '0;
                        r_state <= StIdle;
                    end else begin
                        r_stall <= r_stall + 1'b1;
                    end
                end

                StSend: begin
                    // Done on the busy falling edge, or if busy never rose in time.
                    if (tx_busy) begin
                        r_seen <= 1'b1;
                    end else if (r_seen || (r_wait == 2'd2)) begin
                        r_gap   <= uart_spacing_limit;
                        r_state <= StGap;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end

                StGap: begin
                    if (!w_gap_done) begin
                        r_gap <= r_gap - 1'b1;
                    end else if (r_last) begin
                        r_grant <= 2'b00;
                        r_state <= StIdle;
                    end else if (w_bt_lost) begin
                        r_abort <= 2'b10;
                        r_grant <= 2'b00;
                        r_state <= StIdle;
                    end else begin
                        r_state <= StLoad;
                    end
                end

                default: begin
                    r_grant <= 2'b00;
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hm10_tx_arbiter.sv
// Scoreboard bench for hm10_tx_arbiter: requester and uart_tx models drive the
// DUT, directed stimulus pushes expected bytes/aborts, a monitor pops and checks.
module tb_hm10_tx_arbiter;

    localparam int BUSY_LEN = 10;

    logic       clock = 1'b0;
    logic       resetn;
    logic       bt_state;
    logic [9:0] spacing;
    logic [1:0] req;
    logic [1:0] last;
    logic [7:0] data_0;
    logic [7:0] data_1;
    logic [1:0] ack;
    logic [1:0] abort;
    logic [1:0] grant;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;

    always #5 clock = ~clock;

    hm10_tx_arbiter #(
        .SPACE_W     (10),
        .STALL_LIMIT (255)
    ) u_dut (
        .clock              (clock),
        .resetn             (resetn),
        .bt_state           (bt_state),
        .uart_spacing_limit (spacing),
        .req                (req),
        .last               (last),
        .data_0             (data_0),
        .data_1             (data_1),
        .ack                (ack),
        .abort              (abort),
        .grant              (grant),
        .tx_data            (tx_data),
        .tx_start           (tx_start),
        .tx_busy            (tx_busy)
    );

    // uart_tx model: busy for BUSY_LEN cycles starting the cycle after tx_start.
    int busy_cnt = 0;
    always @(posedge clock) begin
        if (tx_start) busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Requester models: append-only byte lists, pointer advances on ack.
    logic [7:0] mem [0:1][0:63];
    logic       lst [0:1][0:63];
    int         len [0:1] = '{0, 0};
    int         ptr0 = 0;
    int         ptr1 = 0;
    logic       hold0 = 1'b0;

    assign req[0]  = !hold0 && (ptr0 < len[0]);
    assign req[1]  = (ptr1 < len[1]);
    assign data_0  = mem[0][ptr0[5:0]];
    assign data_1  = mem[1][ptr1[5:0]];
    assign last[0] = lst[0][ptr0[5:0]];
    assign last[1] = lst[1][ptr1[5:0]];

    // An aborted message is dropped by its requester.
    function automatic int skip_msg(int ch, int p);
        for (int q = p; q < 64; q++) begin
            if (q < len[ch] && lst[ch][q]) return q + 1;
        end
        return len[ch];
    endfunction

    always @(posedge clock) begin
        if (ack[0]) ptr0 <= ptr0 + 1;
        else if (abort[0]) ptr0 <= skip_msg(0, ptr0);
        if (ack[1]) ptr1 <= ptr1 + 1;
        else if (abort[1]) ptr1 <= skip_msg(1, ptr1);
    end

    // Scoreboard state.
    logic [8:0] exp_tx [$];
    logic [1:0] exp_ab [$];
    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int last_gap = 0;
    int last_start = 0;
    int last_abort = 0;
    int ack_cnt0 = 0;
    int ack_cnt1 = 0;
    logic prev_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic miss(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got 0x%0h, expected nothing", name, act);
    endtask

    task automatic load(input int ch, input logic [7:0] b, input logic l);
        mem[ch][len[ch]] = b;
        lst[ch][len[ch]] = l;
        len[ch]++;
    endtask

    task automatic expect_tx(input logic ch, input logic [7:0] b);
        exp_tx.push_back({ch, b});
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clock);
            if (exp_tx.size() == 0 && exp_ab.size() == 0 && grant == 2'b00 && !tx_busy) break;
        end
        if (k == budget) miss(name, 32'(exp_tx.size() + exp_ab.size()));
    endtask

    task automatic wait_acks(input int ch, input int target, input int budget, input string name);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clock);
            if ((ch == 0 ? ack_cnt0 : ack_cnt1) >= target) break;
        end
        if (k == budget) miss(name, 32'(ch == 0 ? ack_cnt0 : ack_cnt1));
    endtask

    // Monitor: compares every tx_start, ack and abort against the queues.
    initial begin
        logic [8:0] e;
        logic [1:0] a;
        forever begin
            @(negedge clock);
            cyc++;
            if (resetn) begin
                if (prev_busy && !tx_busy) fall_cyc = cyc;
                if (tx_start) begin
                    if (exp_tx.size() == 0) begin
                        miss("tx_unexpected", {22'd0, grant, tx_data});
                    end else begin
                        e = exp_tx.pop_front();
                        chk("tx_byte", 32'(tx_data), 32'(e[7:0]));
                        chk("tx_owner", 32'(grant), 32'(e[8] ? 2'b10 : 2'b01));
                    end
                    last_gap   = cyc - fall_cyc;
                    last_start = cyc;
                end
                if (tx_start || ack != 2'b00)
                    chk("ack_owner", 32'(ack), 32'(tx_start ? grant : 2'b00));
                if (ack[0]) ack_cnt0++;
                if (ack[1]) ack_cnt1++;
                if (abort != 2'b00) begin
                    if (exp_ab.size() == 0) begin
                        miss("abort_unexpected", 32'(abort));
                    end else begin
                        a = exp_ab.pop_front();
                        chk("abort_chan", 32'(abort), 32'(a));
                    end
                    chk("abort_grant", 32'(grant), 32'(0));
                    last_abort = cyc;
                end
            end
            prev_busy = tx_busy;
        end
    end

    initial begin
        int a0;
        int a1;
        resetn   = 1'b0;
        bt_state = 1'b1;
        spacing  = 10'd0;

        // Round-robin setup: both channels hold two 2-byte messages from reset.
        load(0, 8'hB1, 1'b0); load(0, 8'hB2, 1'b1); load(0, 8'hB3, 1'b0); load(0, 8'hB4, 1'b1);
        load(1, 8'hC1, 1'b0); load(1, 8'hC2, 1'b1); load(1, 8'hC3, 1'b0); load(1, 8'hC4, 1'b1);
        repeat (3) @(negedge clock);
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_abort", 32'(abort), 32'(0));
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_tx_start", 32'(tx_start), 32'(0));
        chk("rst_tx_data", 32'(tx_data), 32'(0));

        expect_tx(0, 8'hB1); expect_tx(0, 8'hB2); expect_tx(1, 8'hC1); expect_tx(1, 8'hC2);
        expect_tx(0, 8'hB3); expect_tx(0, 8'hB4); expect_tx(1, 8'hC3); expect_tx(1, 8'hC4);
        resetn = 1'b1;
        wait_idle(1000, "t2_timeout");
        chk("t2_grant_idle", 32'(grant), 32'(0));

        // Three-byte ch0 message, no spacing.
        a0 = ack_cnt0;
        load(0, 8'hA1, 1'b0); load(0, 8'hA2, 1'b0); load(0, 8'hA3, 1'b1);
        expect_tx(0, 8'hA1); expect_tx(0, 8'hA2); expect_tx(0, 8'hA3);
        wait_acks(0, a0 + 2, 200, "t1_ack_timeout");
        repeat (2) @(negedge clock);
        chk("t1_grant_mid", 32'(grant), 32'(2'b01));
        wait_idle(200, "t1_timeout");
        chk("t1_acks", 32'(ack_cnt0 - a0), 32'(3));
        chk("t1_grant_end", 32'(grant), 32'(0));

        // Spacing: busy-fall cycle + gap cycles + LOAD precede the next tx_start.
        spacing = 10'd5;
        load(0, 8'hD1, 1'b0); load(0, 8'hD2, 1'b1);
        expect_tx(0, 8'hD1); expect_tx(0, 8'hD2);
        wait_idle(200, "t3a_timeout");
        chk("t3_gap5", 32'(last_gap), 32'(7));
        spacing = 10'd0;
        load(0, 8'hE1, 1'b0); load(0, 8'hE2, 1'b1);
        expect_tx(0, 8'hE1); expect_tx(0, 8'hE2);
        wait_idle(200, "t3b_timeout");
        chk("t3_gap0", 32'(last_gap), 32'(3));

        // Link loss during byte 2 of a 4-byte ch1 message; ch0 waits then runs.
        a1 = ack_cnt1;
        load(1, 8'hF1, 1'b0); load(1, 8'hF2, 1'b0); load(1, 8'hF3, 1'b0); load(1, 8'hF4, 1'b1);
        expect_tx(1, 8'hF1); expect_tx(1, 8'hF2);
        wait_acks(1, a1 + 2, 200, "t4_ack_timeout");
        bt_state = 1'b0;
        load(0, 8'h61, 1'b1);
        exp_ab.push_back(2'b10);
        expect_tx(0, 8'h61);
        wait_idle(300, "t4_timeout");
        chk("t4_ch1_acks", 32'(ack_cnt1 - a1), 32'(2));

        // ch0 stalls after byte 1; ch1 pending but link down.
        a0 = ack_cnt0;
        load(0, 8'h71, 1'b0); load(0, 8'h72, 1'b0); load(0, 8'h73, 1'b1);
        expect_tx(0, 8'h71);
        wait_acks(0, a0 + 1, 200, "t5_ack_timeout");
        hold0 = 1'b1;
        load(1, 8'h81, 1'b1);
        exp_ab.push_back(2'b01);
        wait_idle(800, "t5_timeout");
        // tx_start at C0, busy fall C11, gap C12, stalls C13..C267, abort C268.
        chk("t5_stall_time", 32'(last_abort - last_start), 32'(268));
        repeat (20) @(negedge clock);
        chk("t5_no_grant_ch1", 32'(grant), 32'(0));
        hold0 = 1'b0;
        expect_tx(1, 8'h81);
        bt_state = 1'b1;
        wait_idle(200, "t5b_timeout");

        // Reset during SEND; afterwards ch0 must win contention again.
        a0 = ack_cnt0;
        load(0, 8'h91, 1'b0); load(0, 8'h92, 1'b1);
        expect_tx(0, 8'h91);
        wait_acks(0, a0 + 1, 200, "t6_ack_timeout");
        repeat (3) @(negedge clock);
        load(1, 8'hA5, 1'b1);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("t6_rst_grant", 32'(grant), 32'(0));
        chk("t6_rst_ack", 32'(ack), 32'(0));
        chk("t6_rst_abort", 32'(abort), 32'(0));
        chk("t6_rst_tx_start", 32'(tx_start), 32'(0));
        chk("t6_rst_tx_data", 32'(tx_data), 32'(0));
        repeat (3) @(negedge clock);
        expect_tx(0, 8'h92); expect_tx(1, 8'hA5);
        resetn = 1'b1;
        @(negedge clock);
        chk("t6_rr_ch0_first", 32'(grant), 32'(2'b01));
        wait_idle(300, "t6_timeout");

        chk("sb_tx_drained", 32'(exp_tx.size()), 32'(0));
        chk("sb_abort_drained", 32'(exp_ab.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
